// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, DX payload field map and field extraction helper.
package pipe_pkg;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;
    localparam int OCC_W     = 2;
    localparam int DX_WIDTH  = 32;
    localparam int DX_FIELDS = 7;
    localparam int DX_PW     = DX_WIDTH * DX_FIELDS;
    localparam int F_PC  = 0;
    localparam int F_A   = 1;
    localparam int F_B   = 2;
    localparam int F_IR  = 3;
    localparam int F_IMM = 4;
    localparam int F_TGT = 5;
    localparam int F_CTL = 6;
    function automatic logic [DX_WIDTH-1:0] get_field(input logic [DX_PW-1:0] d, input int k);
        return d[k*DX_WIDTH +: DX_WIDTH];
    endfunction
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: payload register with load enable, async active-low clear and sync zero.
module pipe_slot #(
    parameter int            PW       = 224,
    parameter logic [PW-1:0] ZERO_VAL = '0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic          zero_i,
    input  logic [PW-1:0] d_i,
    output logic [PW-1:0] q_o
);
    logic [PW-1:0] data_q;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni)     data_q <= '0;
        else if (zero_i) data_q <= ZERO_VAL;
        else if (load_i) data_q <= d_i;
    assign q_o = data_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage with 2-entry skid buffer, stall and flush.
// Define PIPE_STAGE_ZERO_ON_FLUSH_EN to force out_data to FLUSH_VALUE whenever the stage is empty.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               NUM_FIELDS  = 7,
    parameter logic [WIDTH-1:0] FLUSH_VALUE = '0,
    localparam int              PW          = WIDTH * NUM_FIELDS
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [PW-1:0]    in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [PW-1:0]    out_data_o,
    output logic [OCC_W-1:0] occupancy_o
);
    localparam logic [PW-1:0] ZERO_VAL = {NUM_FIELDS{FLUSH_VALUE}};
    state_e        state_q, state_d;
    logic          in_ready_q, in_fire, out_fire;
    logic          main_ld, skid_ld, main_zero, skid_zero;
    logic [PW-1:0] main_d, skid_q;
    assign in_fire  = in_valid_i & in_ready_q;
    assign out_fire = out_valid_o & out_ready_i;
    // in_ready is a flop mirroring "next state is not TWO", so it never depends on out_ready
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= state_d != TWO;
        end
    always_comb begin
        state_d = state_q;
        if (flush_i) state_d = EMPTY;
        else case (state_q)
            EMPTY:   state_d = in_fire ? ONE : EMPTY;
            ONE:     state_d = (in_fire && !out_fire) ? TWO : (!in_fire && out_fire) ? EMPTY : ONE;
            TWO:     state_d = out_fire ? ONE : TWO;
            default: state_d = EMPTY;
        endcase
    end
    always_comb begin
        out_valid_o = state_q != EMPTY;
        in_ready_o  = in_ready_q;
        occupancy_o = state_q == TWO ? OCC_W'(2) : state_q == ONE ? OCC_W'(1) : OCC_W'(0);
        main_ld     = !flush_i && ((state_q == EMPTY && in_fire) || (state_q == ONE && in_fire && out_fire)
                                   || (state_q == TWO && out_fire));
        skid_ld     = !flush_i && state_q == ONE && in_fire && !out_fire;
        main_d      = state_q == TWO ? skid_q : in_data_i;
`ifdef PIPE_STAGE_ZERO_ON_FLUSH_EN
        main_zero   = state_d == EMPTY;
        skid_zero   = flush_i;
`else
        main_zero   = 1'b0;
        skid_zero   = 1'b0;
`endif
    end
    pipe_slot #(.PW(PW), .ZERO_VAL(ZERO_VAL)) u_main (
        .clk_i(clk_i), .rst_ni(rst_ni), .load_i(main_ld), .zero_i(main_zero), .d_i(main_d), .q_o(out_data_o)
    );
    pipe_slot #(.PW(PW), .ZERO_VAL(ZERO_VAL)) u_skid (
        .clk_i(clk_i), .rst_ni(rst_ni), .load_i(skid_ld), .zero_i(skid_zero), .d_i(in_data_i), .q_o(skid_q)
    );
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed checks of handshake, skid ordering, flush and async reset.
module tb_pipe_stage_skid;
    import pipe_pkg::*;
    localparam int PW = DX_PW;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [PW-1:0]    in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [PW-1:0]    out_data;
    logic [OCC_W-1:0] occupancy;
    int n_chk = 0;
    int n_fail = 0;
    pipe_stage_skid dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .occupancy_o(occupancy)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_d(input string tag, input logic [31:0] exp);
        n_chk++;
        assert (out_data === PW'(exp)) else begin
            n_fail++;
            $error("FAIL %s: observed field0 %0h (full %0h) expected %0h", tag, get_field(out_data, F_PC), out_data, exp);
        end
    endtask
    task automatic chk_s(input string tag, input logic v, input logic r, input logic [1:0] o);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".ready"}, 32'(in_ready), 32'(r));
        chk({tag, ".occ"}, 32'(occupancy), 32'(o));
    endtask
    initial begin
        in_valid = 1'b1;
        in_data  = PW'(32'hA5);
        tick();
        tick();
        chk_s("rst_hold", 1'b0, 1'b1, 2'd0);
        chk_d("rst_hold.data", 32'h0);
        rst_n = 1'b1;
        #2;
        chk_s("rst_rel", 1'b0, 1'b1, 2'd0);
        chk_d("rst_rel.data", 32'h0);
        tick();
        chk_s("first", 1'b1, 1'b1, 2'd1);
        chk_d("first.data", 32'hA5);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_s("drain", 1'b0, 1'b1, 2'd0);
        in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = PW'(i);
            tick();
            chk_s($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1);
            chk_d($sformatf("stream%0d.data", i), 32'(i));
        end
        in_valid = 1'b0;
        tick();
        chk_s("stream_end", 1'b0, 1'b1, 2'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = PW'(32'h10);
        tick();
        chk_s("bp0", 1'b1, 1'b1, 2'd1);
        chk_d("bp0.data", 32'h10);
        in_data = PW'(32'h11);
        tick();
        chk_s("bp1", 1'b1, 1'b0, 2'd2);
        chk_d("bp1.data", 32'h10);
        in_data = PW'(32'h12);
        tick();
        chk_s("bp2", 1'b1, 1'b0, 2'd2);
        chk_d("bp2.stable", 32'h10);
        out_ready = 1'b1;
        tick();
        chk_s("rel1", 1'b1, 1'b1, 2'd1);
        chk_d("rel1.data", 32'h11);
        tick();
        chk_s("rel2", 1'b1, 1'b1, 2'd1);
        chk_d("rel2.data", 32'h12);
        in_valid = 1'b0;
        tick();
        chk_s("rel_end", 1'b0, 1'b1, 2'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = PW'(32'h10);
        tick();
        in_data = PW'(32'h20);
        tick();
        chk_s("fl_fill", 1'b1, 1'b0, 2'd2);
        flush   = 1'b1;
        in_data = PW'(32'h33);
        tick();
        chk_s("flush", 1'b0, 1'b1, 2'd0);
`ifdef PIPE_STAGE_ZERO_ON_FLUSH_EN
        chk_d("flush.data", 32'h0);
`else
        chk_d("flush.data", 32'h10);
`endif
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_s("post_flush", 1'b0, 1'b1, 2'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = PW'(32'h40);
        tick();
        in_data = PW'(32'h41);
        tick();
        chk_s("ar_fill", 1'b1, 1'b0, 2'd2);
        chk_d("ar_fill.data", 32'h40);
        #2;
        rst_n = 1'b0;
        #1;
        chk_s("async_rst", 1'b0, 1'b1, 2'd0);
        chk_d("async_rst.data", 32'h0);
        in_valid = 1'b0;
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        chk_s("after_rst", 1'b0, 1'b1, 2'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed 32-bit decode/execute latch.
- Carries NUM_FIELDS payload fields of WIDTH bits each between two pipeline stages.
- Uses a valid/ready handshake and a 2-entry skid buffer, so it sustains full throughput under back-pressure.
- Adds stall and flush semantics the plain enable/flush latch lacks. Instantiated between every stage pair (FD/DX/XM/MW).

Parameters:
- WIDTH, 32, bits per payload field (PC, A, B, IR, imm, target, control…).
- NUM_FIELDS, 7, number of fields; total payload width is PW = WIDTH*NUM_FIELDS.
- FLUSH_VALUE, 0, constant loaded into each field when zeroing; all-zero is the NOP encoding.

Ports:
- clock  in  1  stage clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held and incoming entries.
- in_valid  in  1  upstream has data.
- in_ready  out  1  stage can accept.
- in_data  in  PW  upstream payload; field k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  1  payload at output is live.
- out_ready  in  1  downstream accepts.
- out_data  out  PW  payload to downstream.
- occupancy  out  2  entries held (0..2).

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage:
  - Main slot drives out_data and out_valid directly from flops.
  - Skid slot catches one entry when downstream stalls.
- in_ready = !skid_valid, registered; no combinational in_ready/out_ready path.
- States and transitions (priority: reset > flush > handshake):
  - EMPTY: in_fire -> ONE (main <= in_data).
  - ONE: in_fire & out_fire -> ONE (main <= in_data). in_fire & !out_fire -> TWO (skid <= in_data). !in_fire & out_fire -> EMPTY. Otherwise hold.
  - TWO: in_ready=0. out_fire -> ONE (main <= skid); otherwise hold.
- Ordering: strict FIFO; skid data never bypasses main.
- Latency: 1 cycle from in_fire to out_valid when EMPTY.
- Back-to-back: throughput 1/cycle while out_ready is held high.
- Flush:
  - Next state EMPTY; out_valid=0, in_ready=1, occupancy=0 on the following cycle.
  - An entry presented with in_valid in the flush cycle is dropped, even if in_ready=1.
  - flush with out_ready=1 in the same cycle: the output entry still counts as consumed downstream; the block takes no extra action.
- Reset (asynchronous assert, synchronous deassert at system level):
  - out_valid=0, in_ready=1, occupancy=0, out_data=0, skid cleared.
  - Reset mid-TWO discards both entries.
- occupancy equals 0/1/2 for EMPTY/ONE/TWO.
- Payload flops are written only on load events; out_data is stable while out_valid & !out_ready.

Optional Feature:
- Macro: PIPE_STAGE_ZERO_ON_FLUSH_EN.
- Defined:
  - On flush, both slots are written with FLUSH_VALUE in every field.
  - On any cycle the stage goes EMPTY, main is loaded with FLUSH_VALUE.
  - Result: out_data reads as a NOP whenever out_valid=0, for consumers that ignore valid.
- Undefined:
  - Flush and drain clear only the valid bits; out_data keeps stale contents.
  - Consumers must qualify with out_valid. Saves payload-enable fanout.

Decomposition:
- Package pipe_pkg:
  - State enum {EMPTY, ONE, TWO}.
  - OCC_W=2.
  - Field-index constants for the DX payload (F_PC, F_A, F_B, F_IR, F_IMM, F_TGT, F_CTL).
  - Helper function to extract field k.
- Sub-module pipe_slot: one PW-wide register with load enable, async active-low clear, and optional synchronous zero. Instantiated twice (main, skid).

Test Plan:
- Reset with in_valid=1 held; release reset -> out_valid=0, in_ready=1, occupancy=0, out_data=0 until first clock after release; then 0xA5 (field 0) appears with out_valid=1 one cycle later.
- Stream 0x1..0x8 with out_ready=1 -> out_data 0x1..0x8 on consecutive cycles, no gaps, occupancy stays 1.
- Send 0x10, 0x11, 0x12 with out_ready=0 -> 0x10 in main, 0x11 in skid, in_ready drops, 0x12 held upstream, occupancy=2. Raise out_ready -> 0x10, 0x11, 0x12 emerge in order.
- In TWO state, assert flush with in_valid=1 (data 0x33) -> next cycle out_valid=0, occupancy=0, in_ready=1; 0x33 never appears.
- Build: with PIPE_STAGE_ZERO_ON_FLUSH_EN, after flush out_data==0. Without the macro, out_data retains its pre-flush value, e.g. 0x10.
- Assert reset asynchronously mid-cycle while occupancy=2 -> outputs clear immediately, before the next clock edge.
